// File: rtl/multicycle_control.sv
// Multicycle control FSM for the TSC CPU: sequences IF/ID/EX/MEM/WB, runs the
// memory read/write handshakes, counts retired instructions and flags halt.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func,
    input  logic             inputReady,
    input  logic             ackOutput,
    output logic             readM,
    output logic             writeM,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic [1:0]       alu_src_b,
    output logic             IsALU,
    output logic             output_active,
    output logic             is_halted,
    output logic [CNT_W-1:0] num_inst
);

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HLT
    } state_t;

    typedef enum logic [3:0] {
        K_RTYPE,
        K_ADI,
        K_ORI,
        K_LHI,
        K_LWD,
        K_SWD,
        K_BRANCH,
        K_JMP,
        K_JAL,
        K_JPR,
        K_JRL,
        K_WWD,
        K_HLT,
        K_NOP
    } kind_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_inst_q, num_inst_d;
    kind_t            kind;
    logic             mem_read;
    logic             mem_write;
    logic             retire;

    // Classify the held IR; anything not in the ISA collapses to a NOP.
    always_comb begin
        kind = K_NOP;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: kind = K_BRANCH;
            4'd4:  kind = K_ADI;
            4'd5:  kind = K_ORI;
            4'd6:  kind = K_LHI;
            4'd7:  kind = K_LWD;
            4'd8:  kind = K_SWD;
            4'd9:  kind = K_JMP;
            4'd10: kind = K_JAL;
            4'd15: begin
                case (func)
                    6'd0, 6'd1, 6'd2, 6'd3,
                    6'd4, 6'd5, 6'd6, 6'd7: kind = K_RTYPE;
                    6'd25:   kind = K_JPR;
                    6'd26:   kind = K_JRL;
                    6'd28:   kind = K_WWD;
                    6'd29:   kind = K_HLT;
                    default: kind = K_NOP;
                endcase
            end
            default: kind = K_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IF;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (inputReady) state_d = S_ID;
            end
            S_ID: begin
                case (kind)
                    K_JMP, K_JPR, K_NOP: state_d = S_IF;
                    K_JAL, K_JRL:        state_d = S_WB;
                    K_HLT:               state_d = S_HLT;
                    default:             state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (kind)
                    K_LWD, K_SWD:                   state_d = S_MEM;
                    K_RTYPE, K_ADI, K_ORI, K_LHI:   state_d = S_WB;
                    default:                        state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (kind == K_LWD) begin
                    if (inputReady) state_d = S_WB;
                end else if (kind == K_SWD) begin
                    if (ackOutput) state_d = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            S_HLT:   state_d = S_HLT;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires on the edge that leaves it for IF or HLT.
    always_comb begin
        retire = (state_q != S_IF) && (state_q != S_HLT) &&
                 ((state_d == S_IF) || (state_d == S_HLT));
        num_inst_d = retire ? (num_inst_q + CNT_W'(1)) : num_inst_q;
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        wb_src        = 2'd0;
        alu_src_b     = 2'd0;
        IsALU         = 1'b0;
        output_active = 1'b0;
        is_halted     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
            end
            S_ID: begin
                pc_write = (kind != K_HLT);
                case (kind)
                    K_JMP, K_JAL: pc_src = 2'd2;
                    K_JPR, K_JRL: pc_src = 2'd3;
                    default:      pc_src = 2'd0;
                endcase
            end
            S_EX: begin
                IsALU = (opcode == 4'd15);
                case (kind)
                    K_ADI, K_LWD, K_SWD, K_BRANCH: alu_src_b = 2'd1;
                    K_ORI:                         alu_src_b = 2'd2;
                    default:                       alu_src_b = 2'd0;
                endcase
                if (kind == K_BRANCH) begin
                    pc_write_cond = 1'b1;
                    pc_src        = 2'd1;
                end
                output_active = (kind == K_WWD);
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (kind == K_LWD);
                mem_write = (kind == K_SWD);
            end
            S_WB: begin
                reg_write = 1'b1;
                case (kind)
                    K_RTYPE: begin
                        reg_dst = 2'd1;
                        wb_src  = 2'd0;
                    end
                    K_LHI:   wb_src = 2'd3;
                    K_LWD:   wb_src = 2'd1;
                    K_JAL, K_JRL: begin
                        reg_dst = 2'd2;
                        wb_src  = 2'd2;
                    end
                    default: begin
                        reg_dst = 2'd0;
                        wb_src  = 2'd0;
                    end
                endcase
            end
            S_HLT: begin
                is_halted = 1'b1;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    // Memory strobes and the IR latch drop the instant reset rises, even though
    // the state register already reads IF.
    assign readM    = mem_read & ~reset;
    assign writeM   = mem_write & ~reset;
    assign ir_write = (state_q == S_IF) & inputReady & ~reset;
    assign num_inst = num_inst_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words go
// through a scoreboard queue and are checked with immediate assertions.
module tb_multicycle_control;

    localparam int CNT_W = 16;

    localparam logic [17:0] RD    = 18'd1 << 17;
    localparam logic [17:0] WR    = 18'd1 << 16;
    localparam logic [17:0] IOD   = 18'd1 << 15;
    localparam logic [17:0] IRW   = 18'd1 << 14;
    localparam logic [17:0] PCW   = 18'd1 << 13;
    localparam logic [17:0] PCWC  = 18'd1 << 12;
    localparam logic [17:0] RW    = 18'd1 << 9;
    localparam logic [17:0] ISALU = 18'd1 << 2;
    localparam logic [17:0] OA    = 18'd1 << 1;
    localparam logic [17:0] HALT  = 18'd1;

    typedef struct packed {
        logic [17:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       opcode;
    logic [5:0]       func;
    logic             inputReady;
    logic             ackOutput;
    logic             readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]       pc_src, reg_dst, wb_src, alu_src_b;
    logic             reg_write, IsALU, output_active, is_halted;
    logic [CNT_W-1:0] num_inst;
    logic [17:0]      ctrl_obs;

    exp_t  expQ[$];
    string tagQ[$];
    int    assertCount = 0;
    int    failCount   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .inputReady(inputReady), .ackOutput(ackOutput),
        .readM(readM), .writeM(writeM), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
        .alu_src_b(alu_src_b), .IsALU(IsALU), .output_active(output_active),
        .is_halted(is_halted), .num_inst(num_inst)
    );

    assign ctrl_obs = {readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond,
                       pc_src, reg_write, reg_dst, wb_src, alu_src_b,
                       IsALU, output_active, is_halted};

    function automatic logic [17:0] PCS(input logic [1:0] v);
        return {6'b0, v, 10'b0};
    endfunction
    function automatic logic [17:0] RDST(input logic [1:0] v);
        return {9'b0, v, 7'b0};
    endfunction
    function automatic logic [17:0] WBS(input logic [1:0] v);
        return {11'b0, v, 5'b0};
    endfunction
    function automatic logic [17:0] ASB(input logic [1:0] v);
        return {13'b0, v, 3'b0};
    endfunction

    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic [5:0] fn, input logic ir,
                                 input logic ack, input logic [17:0] ec,
                                 input logic [CNT_W-1:0] en);
        exp_t e;
        opcode     = op;
        func       = fn;
        inputReady = ir;
        ackOutput  = ack;
        e.ctrl     = ec;
        e.cnt      = en;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard_empty observed 0 entries required 1");
            return;
        end
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        assertCount++;
        assert (ctrl_obs === e.ctrl) else begin
            failCount++;
            $display("[TB] FAIL %s ctrl observed %b expected %b", tag, ctrl_obs, e.ctrl);
            $error("[TB] ctrl assertion %s", tag);
        end
        assertCount++;
        assert (num_inst === e.cnt) else begin
            failCount++;
            $display("[TB] FAIL %s num_inst observed %0d expected %0d", tag, num_inst, e.cnt);
            $error("[TB] num_inst assertion %s", tag);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] op, input logic [5:0] fn,
                       input logic ir, input logic ack, input logic [17:0] ec,
                       input logic [CNT_W-1:0] en);
        applyStimulus(tag, op, fn, ir, ack, ec, en);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Raise reset mid-cycle and confirm everything drops before the next edge.
    task automatic asyncReset(input string tag, input logic ir);
        reset = 1'b1;
        applyStimulus(tag, opcode, func, ir, 1'b0, 18'd0, '0);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus("reset_state", 4'd0, 6'd0, 1'b0, 1'b0, 18'd0, '0);
        #3;
        checkOutput();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc("if_idle",      4'd15, 6'd0,  1'b0, 1'b0, RD, 0);
        cyc("add_if",       4'd15, 6'd0,  1'b1, 1'b0, RD | IRW, 0);
        cyc("add_id",       4'd15, 6'd0,  1'b0, 1'b0, PCW, 0);
        cyc("add_ex",       4'd15, 6'd0,  1'b0, 1'b0, ISALU, 0);
        cyc("add_wb",       4'd15, 6'd0,  1'b0, 1'b0, RW | RDST(2'd1), 0);

        cyc("lwd_if",       4'd7,  6'd0,  1'b1, 1'b0, RD | IRW, 1);
        cyc("lwd_id",       4'd7,  6'd0,  1'b0, 1'b0, PCW, 1);
        cyc("lwd_ex",       4'd7,  6'd0,  1'b0, 1'b0, ASB(2'd1), 1);
        cyc("lwd_mem_w0",   4'd7,  6'd0,  1'b0, 1'b0, RD | IOD, 1);
        cyc("lwd_mem_w1",   4'd7,  6'd0,  1'b0, 1'b1, RD | IOD, 1);
        cyc("lwd_mem_w2",   4'd7,  6'd0,  1'b0, 1'b0, RD | IOD, 1);
        cyc("lwd_mem_rdy",  4'd7,  6'd0,  1'b1, 1'b0, RD | IOD, 1);
        cyc("lwd_wb",       4'd7,  6'd0,  1'b0, 1'b0, RW | WBS(2'd1), 1);

        cyc("beq_if",       4'd1,  6'd0,  1'b1, 1'b0, RD | IRW, 2);
        cyc("beq_id",       4'd1,  6'd0,  1'b0, 1'b0, PCW, 2);
        cyc("beq_ex",       4'd1,  6'd0,  1'b0, 1'b0, PCWC | PCS(2'd1) | ASB(2'd1), 2);

        cyc("jal_if",       4'd10, 6'd0,  1'b1, 1'b0, RD | IRW, 3);
        cyc("jal_id",       4'd10, 6'd0,  1'b0, 1'b0, PCW | PCS(2'd2), 3);
        cyc("jal_wb",       4'd10, 6'd0,  1'b0, 1'b0, RW | RDST(2'd2) | WBS(2'd2), 3);

        cyc("wwd_if",       4'd15, 6'd28, 1'b1, 1'b0, RD | IRW, 4);
        cyc("wwd_id",       4'd15, 6'd28, 1'b0, 1'b0, PCW, 4);
        cyc("wwd_ex",       4'd15, 6'd28, 1'b0, 1'b0, ISALU | OA, 4);

        cyc("jmp_if",       4'd9,  6'd0,  1'b1, 1'b0, RD | IRW, 5);
        cyc("jmp_id",       4'd9,  6'd0,  1'b0, 1'b0, PCW | PCS(2'd2), 5);

        cyc("jpr_if",       4'd15, 6'd25, 1'b1, 1'b0, RD | IRW, 6);
        cyc("jpr_id",       4'd15, 6'd25, 1'b0, 1'b0, PCW | PCS(2'd3), 6);

        cyc("ori_if",       4'd5,  6'd0,  1'b1, 1'b0, RD | IRW, 7);
        cyc("ori_id",       4'd5,  6'd0,  1'b0, 1'b0, PCW, 7);
        cyc("ori_ex",       4'd5,  6'd0,  1'b0, 1'b0, ASB(2'd2), 7);
        cyc("ori_wb",       4'd5,  6'd0,  1'b0, 1'b0, RW, 7);

        cyc("nop_if",       4'd12, 6'd0,  1'b1, 1'b0, RD | IRW, 8);
        cyc("nop_id",       4'd12, 6'd0,  1'b0, 1'b0, PCW, 8);

        cyc("swd_if",       4'd8,  6'd0,  1'b1, 1'b0, RD | IRW, 9);
        cyc("swd_id",       4'd8,  6'd0,  1'b0, 1'b0, PCW, 9);
        cyc("swd_ex",       4'd8,  6'd0,  1'b0, 1'b0, ASB(2'd1), 9);
        cyc("swd_mem_stray",4'd8,  6'd0,  1'b1, 1'b0, WR | IOD, 9);
        cyc("swd_mem_ack",  4'd8,  6'd0,  1'b0, 1'b1, WR | IOD, 9);

        cyc("if_wait",      4'd8,  6'd0,  1'b0, 1'b0, RD, 10);
        asyncReset("rst_mid_if", 1'b0);
        cyc("post_rst_if",  4'd8,  6'd0,  1'b0, 1'b0, RD, 0);

        cyc("swd2_if",      4'd8,  6'd0,  1'b1, 1'b0, RD | IRW, 0);
        cyc("swd2_id",      4'd8,  6'd0,  1'b0, 1'b0, PCW, 0);
        cyc("swd2_ex",      4'd8,  6'd0,  1'b0, 1'b0, ASB(2'd1), 0);
        cyc("swd2_mem",     4'd8,  6'd0,  1'b0, 1'b0, WR | IOD, 0);
        asyncReset("rst_mid_swd", 1'b1);
        cyc("post_rst2_if", 4'd15, 6'd29, 1'b0, 1'b0, RD, 0);

        cyc("hlt_if",       4'd15, 6'd29, 1'b1, 1'b0, RD | IRW, 0);
        cyc("hlt_id",       4'd15, 6'd29, 1'b0, 1'b0, 18'd0, 0);
        for (int i = 0; i < 21; i++) begin
            cyc("hlt_hold", 4'd15, 6'd29, i[0], ~i[0], HALT, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
